pixel_scan_tracker: RTL and testbench
=====================================

# pixel_scan_tracker

Parametrised pixel-coordinate tracker that sits between the TMDS serialiser's pixel-request strobes (`i_rd`, `i_newline`, `i_newframe`) and the pixel-generating core, all in the pixel clock domain. It converts the strobes into registered raster counts, signed origin-relative coordinates and start/end-of-line/frame flags for the pixel core. It also keeps a frame counter and, optionally, checks raster geometry. It generalises the fixed 640x480 inline counters with configurable geometry and origin, a defined same-cycle strobe priority, and registered outputs.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `H_BITS`, 12: width of `o_hcount`; `o_x` is `H_BITS+1`.
- `V_BITS`, 12: width of `o_vcount`; `o_y` is `V_BITS+1`.
- `X_ORIGIN`, 320: hcount mapped to x = 0.
- `Y_ORIGIN`, 240: vcount mapped to y = 0; y increases upward.
- `FRAME_BITS`, 8: width of `o_frame`.
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high.
- `i_rd`  in  1  serialiser consumes a pixel this cycle.
- `i_newline`  in  1  start of line.
- `i_newframe`  in  1  start of frame.
- `o_req`  out  1  registered copy of `i_rd`.
- `o_hcount`  out  H_BITS  pixel index of the emitted pixel.
- `o_vcount`  out  V_BITS  line index of the emitted pixel.
- `o_x`  out  H_BITS+1  signed, `o_hcount - X_ORIGIN`.
- `o_y`  out  V_BITS+1  signed, `Y_ORIGIN - o_vcount`.
- `o_sof`, `o_eol`, `o_eof`  out  1 each  start of frame, end of line, end of frame.
- `o_frame`  out  FRAME_BITS  completed-frame count.
- `o_err_line`, `o_err_frame`  out  1 each  sticky geometry errors.

## Operation
- Internal counters: `hcnt` (H_BITS), `vcnt` (V_BITS), `lines_seen` (V_BITS), `armed` (1 bit).
- Effective values are computed each cycle:
  - `h_eff = i_newline ? 0 : hcnt`
  - `v_eff = i_newframe ? 0 : (i_newline ? vcnt+1 : vcnt)`
- A coincident `i_newframe` overrides `i_newline` for `vcnt`.
- `i_rd` coincident with `i_newline` is a real pixel tagged as index 0; it is not dropped.
- Register updates:
  - `hcnt <= h_eff + i_rd`
  - `vcnt <= v_eff`
- All count arithmetic wraps modulo 2^width and never saturates.
- Pixel stage: on a cycle with `i_rd`, the next cycle presents:
  - `o_req`=1, `o_hcount`=`h_eff`, `o_vcount`=`v_eff`
  - `o_x`, `o_y` sign-extended before subtraction
  - `o_sof` = (`h_eff`==0 && `v_eff`==0)
  - `o_eol` = (`h_eff`==H_ACTIVE-1)
  - `o_eof` = `o_eol` && `v_eff`==V_ACTIVE-1
- On a cycle without `i_rd`, the next cycle has `o_req`, `o_sof`, `o_eol` and `o_eof` at 0. Coordinate outputs hold their last value.
- `o_frame` increments by 1 in the same cycle `o_eof` is asserted, and wraps.

## Timing
- Latency: strobe at cycle N gives outputs at cycle N+1. All outputs are registered.
- Reset: the cycle after `reset` is sampled high, all counters, `armed` and every output are 0, except `o_x`=-X_ORIGIN and `o_y`=Y_ORIGIN.
- `reset` has priority over every strobe. Reset mid-line discards partial counts.
- The first pixel after reset with no `i_newframe` is tagged (0,0) and `o_sof`=1.
- Strobes may arrive back to back with no gaps. There is no backpressure.

## Configuration
- `SCAN_CHECK_EN` defined:
  - `armed` sets on the first `i_newframe` after reset.
  - While armed, `i_newline` with `hcnt` not 0 and not H_ACTIVE sets `o_err_line`.
  - `lines_seen` counts lines with `hcnt`==H_ACTIVE at `i_newline`.
  - While armed, `i_newframe` with `lines_seen` != V_ACTIVE sets `o_err_frame`; `lines_seen` then clears.
  - Errors appear 1 cycle after the offending strobe. Only `reset` clears them.
- `SCAN_CHECK_EN` undefined: the error outputs are tied to 0 and the check logic is absent.

## Test plan
- Reset, then `i_newframe`, then 640 consecutive `i_rd` -> `o_x` runs -320..319, `o_y`=240; `o_sof` on the first pixel only; `o_eol` on pixel 639; `o_frame` stays 0.
- Full 640x480 raster with blanking gaps -> a single `o_eof` at (639,479) with `o_y`=-239; `o_frame` becomes 1; no errors.
- `i_rd` together with `i_newline` at vcount 5 -> that pixel reports `o_hcount`=0, `o_vcount`=6; the next pixel reports hcount 1.
- `i_newframe` together with `i_newline` -> the next pixel reports vcount 0 and `o_sof`=1.
- With `SCAN_CHECK_EN` defined: after an armed frame, a line of 639 reads then `i_newline` -> `o_err_line`=1 on the next cycle, held through later good frames; a frame with 479 full lines -> `o_err_frame`=1.
- Assert `reset` at pixel 300 of line 10 -> next cycle all outputs are at reset values; the following pixel reports (0,0).

Source files
------------

// File: rtl/pixel_scan_tracker.sv
// Pixel-clock raster tracker: turns serialiser strobes into registered counts, origin-relative
// coordinates and SOF/EOL/EOF flags. Define SCAN_CHECK_EN to add sticky raster-geometry checks.
module pixel_scan_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_BITS     = 12,
    parameter int V_BITS     = 12,
    parameter int X_ORIGIN   = 320,
    parameter int Y_ORIGIN   = 240,
    parameter int FRAME_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_rd,
    input  logic                    i_newline,
    input  logic                    i_newframe,
    output logic                    o_req,
    output logic [H_BITS-1:0]       o_hcount,
    output logic [V_BITS-1:0]       o_vcount,
    output logic signed [H_BITS:0]  o_x,
    output logic signed [V_BITS:0]  o_y,
    output logic                    o_sof,
    output logic                    o_eol,
    output logic                    o_eof,
    output logic [FRAME_BITS-1:0]   o_frame,
    output logic                    o_err_line,
    output logic                    o_err_frame
);

    localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_ACTIVE - 1);
    localparam logic [H_BITS-1:0] H_FULL = H_BITS'(H_ACTIVE);
    localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_ACTIVE - 1);
    localparam logic [H_BITS:0]   X_ORG  = (H_BITS+1)'(X_ORIGIN);
    localparam logic [V_BITS:0]   Y_ORG  = (V_BITS+1)'(Y_ORIGIN);

    logic [H_BITS-1:0] hcnt;
    logic [H_BITS-1:0] h_eff;
    logic [V_BITS-1:0] vcnt;
    logic [V_BITS-1:0] v_eff;
    logic              eol_next;
    logic              eof_next;

    // newframe outranks newline for the line index; a read alongside newline is pixel 0
    always_comb begin
        h_eff = i_newline ? '0 : hcnt;
        if (i_newframe)
            v_eff = '0;
        else if (i_newline)
            v_eff = vcnt + V_BITS'(1);
        else
            v_eff = vcnt;
        eol_next = (h_eff == H_LAST);
        eof_next = eol_next && (v_eff == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt     <= '0;
            vcnt     <= '0;
            o_req    <= 1'b0;
            o_hcount <= '0;
            o_vcount <= '0;
            o_x      <= -X_ORG;
            o_y      <= Y_ORG;
            o_sof    <= 1'b0;
            o_eol    <= 1'b0;
            o_eof    <= 1'b0;
            o_frame  <= '0;
        end else begin
            hcnt  <= h_eff + H_BITS'(i_rd);
            vcnt  <= v_eff;
            o_req <= i_rd;
            o_sof <= i_rd && (h_eff == '0) && (v_eff == '0);
            o_eol <= i_rd && eol_next;
            o_eof <= i_rd && eof_next;
            // coordinates only move on emitted pixels and hold through blanking
            if (i_rd) begin
                o_hcount <= h_eff;
                o_vcount <= v_eff;
                o_x      <= {1'b0, h_eff} - X_ORG;
                o_y      <= Y_ORG - {1'b0, v_eff};
                if (eof_next)
                    o_frame <= o_frame + FRAME_BITS'(1);
            end
        end
    end

`ifdef SCAN_CHECK_EN
    logic              armed;
    logic [V_BITS-1:0] lines_seen;
    logic [V_BITS-1:0] lines_final;
    logic              line_full;

    // a newline coincident with newframe still closes the last line of the old frame
    always_comb begin
        line_full   = i_newline && (hcnt == H_FULL);
        lines_final = lines_seen + V_BITS'(line_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed       <= 1'b0;
            lines_seen  <= '0;
            o_err_line  <= 1'b0;
            o_err_frame <= 1'b0;
        end else begin
            if (i_newframe)
                armed <= 1'b1;
            if (armed && i_newline && (hcnt != '0) && (hcnt != H_FULL))
                o_err_line <= 1'b1;
            if (i_newframe) begin
                if (armed && (lines_final != V_BITS'(V_ACTIVE)))
                    o_err_frame <= 1'b1;
                lines_seen <= '0;
            end else if (line_full) begin
                lines_seen <= lines_final;
            end
        end
    end
`else
    assign o_err_line  = 1'b0;
    assign o_err_frame = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_scan_tracker.sv
// Directed bench for pixel_scan_tracker: default 640x480 instance plus a tiny 8x4 instance for
// whole-frame and geometry-error sequences (error expectations follow SCAN_CHECK_EN).
module tb_pixel_scan_tracker;

`ifdef SCAN_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk;
    logic rst, rd, nl, nf, sel;
    int   n_tests, n_fail, a_eof_cnt;

    logic        a_req, a_sof, a_eol, a_eof, a_el, a_ef;
    logic [11:0] a_hcount, a_vcount;
    logic signed [12:0] a_x, a_y;
    logic [7:0]  a_frame;

    logic        b_req, b_sof, b_eol, b_eof, b_el, b_ef;
    logic [3:0]  b_hcount;
    logic [2:0]  b_vcount;
    logic signed [4:0] b_x;
    logic signed [3:0] b_y;
    logic [1:0]  b_frame;

    pixel_scan_tracker u_dut (
        .clk(clk), .reset(rst && !sel), .i_rd(rd && !sel), .i_newline(nl && !sel),
        .i_newframe(nf && !sel), .o_req(a_req), .o_hcount(a_hcount), .o_vcount(a_vcount),
        .o_x(a_x), .o_y(a_y), .o_sof(a_sof), .o_eol(a_eol), .o_eof(a_eof),
        .o_frame(a_frame), .o_err_line(a_el), .o_err_frame(a_ef)
    );

    pixel_scan_tracker #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BITS(4), .V_BITS(3),
        .X_ORIGIN(4), .Y_ORIGIN(2), .FRAME_BITS(2)
    ) u_small (
        .clk(clk), .reset(rst && sel), .i_rd(rd && sel), .i_newline(nl && sel),
        .i_newframe(nf && sel), .o_req(b_req), .o_hcount(b_hcount), .o_vcount(b_vcount),
        .o_x(b_x), .o_y(b_y), .o_sof(b_sof), .o_eol(b_eol), .o_eof(b_eof),
        .o_frame(b_frame), .o_err_line(b_el), .o_err_frame(b_ef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive one cycle of strobes, then sample just after the edge that registers them
    task automatic cyc(input logic r, input logic l, input logic f);
        rd = r; nl = l; nf = f;
        @(posedge clk);
        #1;
        if (a_eof) a_eof_cnt++;
    endtask

    task automatic pix(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // newline, one blanking cycle, then a run of pixels
    task automatic b_line(input int len);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        pix(len);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; a_eof_cnt = 0;
        rst = 1'b0; rd = 1'b0; nl = 1'b0; nf = 1'b0; sel = 1'b0;

        // reset values of the default instance
        do_reset();
        chk("rst_req", int'(a_req), 0);
        chk("rst_hcount", int'(a_hcount), 0);
        chk("rst_vcount", int'(a_vcount), 0);
        chk("rst_x", int'(a_x), -320);
        chk("rst_y", int'(a_y), 240);
        chk("rst_flags", int'({a_sof, a_eol, a_eof}), 0);
        chk("rst_frame", int'(a_frame), 0);
        chk("rst_err", int'({a_el, a_ef}), 0);

        // first line: x sweeps -320..319
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 640; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("l0_x", int'(a_x), i - 320);
            chk("l0_y", int'(a_y), 240);
            chk("l0_sof", int'(a_sof), (i == 0) ? 1 : 0);
            chk("l0_eol", int'(a_eol), (i == 639) ? 1 : 0);
            chk("l0_eof", int'(a_eof), 0);
            chk("l0_frame", int'(a_frame), 0);
        end

        // short middle lines, then a full final line 479
        for (int l = 1; l < 479; l++) begin
            cyc(1'b0, 1'b1, 1'b0);
            pix(2);
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 640; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i == 638) chk("pre_eof_frame", int'(a_frame), 0);
            if (i == 639) begin
                chk("eof_flag", int'(a_eof), 1);
                chk("eof_hcount", int'(a_hcount), 639);
                chk("eof_vcount", int'(a_vcount), 479);
                chk("eof_y", int'(a_y), -239);
                chk("eof_frame", int'(a_frame), 1);
            end
        end
        chk("eof_count", a_eof_cnt, 1);

        // read coincident with newline at line 5
        do_reset();
        cyc(1'b0, 1'b1, 1'b1);
        for (int l = 0; l < 5; l++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk("rdnl_hcount", int'(a_hcount), 0);
        chk("rdnl_vcount", int'(a_vcount), 6);
        chk("rdnl_x", int'(a_x), -320);
        chk("rdnl_y", int'(a_y), 234);
        chk("rdnl_req", int'(a_req), 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rdnl_next_h", int'(a_hcount), 1);
        chk("rdnl_next_v", int'(a_vcount), 6);
        chk("rdnl_next_x", int'(a_x), -319);

        // newframe with newline
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("nfnl_hcount", int'(a_hcount), 0);
        chk("nfnl_vcount", int'(a_vcount), 0);
        chk("nfnl_sof", int'(a_sof), 1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("nfnlrd_v", int'(a_vcount), 0);
        chk("nfnlrd_sof", int'(a_sof), 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("nfnlrd_next_h", int'(a_hcount), 1);
        chk("nfnlrd_next_sof", int'(a_sof), 0);

        // reset at pixel 300 of line 10
        cyc(1'b0, 1'b1, 1'b1);
        for (int l = 0; l < 10; l++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
        end
        pix(299);
        chk("mid_hcount", int'(a_hcount), 299);
        chk("mid_vcount", int'(a_vcount), 10);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mrst_req", int'(a_req), 0);
        chk("mrst_hv", int'({a_hcount, a_vcount}), 0);
        chk("mrst_x", int'(a_x), -320);
        chk("mrst_y", int'(a_y), 240);
        chk("mrst_flags", int'({a_sof, a_eol, a_eof}), 0);
        chk("mrst_err", int'({a_el, a_ef}), 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("post_rst_hv", int'({a_hcount, a_vcount}), 0);
        chk("post_rst_sof", int'(a_sof), 1);
        chk("post_rst_req", int'(a_req), 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("idle_req", int'(a_req), 0);
        chk("idle_sof", int'(a_sof), 0);
        chk("idle_x_hold", int'(a_x), -320);
        cyc(1'b1, 1'b0, 1'b0);
        chk("post_idle_h", int'(a_hcount), 1);

        // 8x4 instance: full good frame
        sel = 1'b1;
        do_reset();
        chk("b_rst_x", int'(b_x), -4);
        chk("b_rst_y", int'(b_y), 2);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("b_first_sof", int'(b_sof), 1);
        chk("b_first_x", int'(b_x), -4);
        pix(7);
        chk("b_l0_eol", int'(b_eol), 1);
        chk("b_l0_eof", int'(b_eof), 0);
        b_line(8); b_line(8); b_line(8);
        chk("b_eof", int'(b_eof), 1);
        chk("b_eof_xy", int'(b_x) * 100 + int'(b_y), 3 * 100 - 1);
        chk("b_eof_v", int'(b_vcount), 3);
        chk("b_frame1", int'(b_frame), 1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("b_good_el", int'(b_el), 0);
        chk("b_good_ef", int'(b_ef), 0);

        // short line 0 (7 pixels) then newline
        pix(7);
        cyc(1'b0, 1'b1, 1'b0);
        chk("b_short_el", int'(b_el), CHK);
        chk("b_short_ef", int'(b_ef), 0);
        cyc(1'b0, 1'b0, 1'b0);
        pix(8); b_line(8); b_line(8);
        cyc(1'b0, 1'b1, 1'b1);
        chk("b_bad_ef", int'(b_ef), CHK);
        chk("b_el_hold", int'(b_el), CHK);
        pix(8); b_line(8); b_line(8); b_line(8);
        chk("b_frame3", int'(b_frame), 3);
        cyc(1'b0, 1'b1, 1'b1);
        chk("b_el_sticky", int'(b_el), CHK);
        chk("b_ef_sticky", int'(b_ef), CHK);

        // only three full lines in an armed frame
        do_reset();
        chk("b_rst_err", int'({b_el, b_ef}), 0);
        cyc(1'b0, 1'b1, 1'b1);
        pix(8); b_line(8); b_line(8);
        cyc(1'b0, 1'b1, 1'b1);
        chk("b_3line_ef", int'(b_ef), CHK);
        chk("b_3line_el", int'(b_el), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
